// File: rtl/handshake_pkg.sv
// Shared types and helpers for the handshake round-robin arbiter.
package handshake_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Round-robin priority select: first asserted request at or above ptr, wrapping.
module rr_pick
    import handshake_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    int k;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        k     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[k]) begin
                found = 1'b1;
                index = IW'(k);
            end
        end
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Packet-aware round-robin arbiter with a full-throughput registered output.
module handshake_rr_arbiter
    import handshake_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    localparam int IW     = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        valid_pre_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_pre_i,
    input  logic [NUM_REQ-1:0]        last_pre_i,
    output logic [NUM_REQ-1:0]        ready_pre_o,
    output logic                      valid_post_o,
    output logic [DATA_W-1:0]         data_post_o,
    output logic                      last_post_o,
    output logic [IW-1:0]             src_post_o,
    input  logic                      ready_post_i
);

    arb_state_t        state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gnt;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     sel;
    logic [IW-1:0]     ptr_nxt;
    logic              found;
    logic              grant_ok;
    logic              can_load;
    logic              sel_valid;
    logic              sel_last;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (valid_pre_i),
        .ptr   (ptr),
        .found (found),
        .index (pick)
    );

    // A held lock overrides the round-robin pick until the packet closes.
    always_comb begin
        sel         = (state == ARB_LOCKED) ? gnt : pick;
        grant_ok    = (state == ARB_LOCKED) || found;
        can_load    = !valid_post_o || ready_post_i;
        sel_valid   = valid_pre_i[sel];
        sel_last    = last_pre_i[sel];
        sel_data    = data_pre_i[int'(sel)*DATA_W +: DATA_W];
        ptr_nxt     = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        xfer        = rst_n && grant_ok && can_load && sel_valid;
        ready_pre_o = '0;
        if (rst_n && grant_ok && can_load) begin
            ready_pre_o[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            ptr          <= '0;
            gnt          <= '0;
            valid_post_o <= 1'b0;
            data_post_o  <= '0;
            last_post_o  <= 1'b0;
            src_post_o   <= '0;
        end else begin
            if (can_load) begin
                valid_post_o <= xfer;
                if (xfer) begin
                    data_post_o <= sel_data;
                    last_post_o <= sel_last;
                    src_post_o  <= sel;
                end
            end
            if (xfer) begin
                if (sel_last) begin
                    state <= ARB_IDLE;
                    ptr   <= ptr_nxt;
                end else begin
                    state <= ARB_LOCKED;
                    gnt   <= sel;
                end
            end
        end
    end

endmodule

// File: doc/handshake_rr_arbiter.md
HANDSHAKE_RR_ARBITER -- requirements
Module: handshake_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of upstream requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, payload width per beat.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_pre_i  input  NUM_REQ  per-requester valid.
REQ-006 SHALL have port data_pre_i  input  NUM_REQ*DATA_W  per-requester payload; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port last_pre_i  input  NUM_REQ  per-requester end-of-packet marker.
REQ-008 SHALL have port ready_pre_o  output  NUM_REQ  per-requester ready.
REQ-009 SHALL have port valid_post_o  output  1  registered output valid.
REQ-010 SHALL have port data_post_o  output  DATA_W  registered output payload.
REQ-011 SHALL have port last_post_o  output  1  registered end-of-packet marker.
REQ-012 SHALL have port src_post_o  output  clog2(NUM_REQ)  index of the requester that produced the current output beat.
REQ-013 SHALL have port ready_post_i  input  1  downstream ready.

Function
REQ-014 Transfer rule: a beat moves on a channel only in a cycle where valid and ready are both high at the rising edge.
REQ-015 Output stage SHALL be one full-throughput register: loads when valid_post_o is low or ready_post_i is high; latency 1 cycle; 1 beat/cycle sustained.
REQ-016 While valid_post_o=1 and ready_post_i=0, data_post_o, last_post_o and src_post_o SHALL hold stable.
REQ-017 FSM states: IDLE (no grant held) and LOCKED (grant held by requester g).
REQ-018 In IDLE, grant SHALL go to the first asserted valid_pre_i at or after index ptr, searching upward modulo NUM_REQ (round-robin).
REQ-019 ready_pre_o[k] SHALL be high only for the granted k and only when the output stage can load (REQ-015); all other bits low.
REQ-020 IDLE->LOCKED when the granted beat transfers with last_pre_i=0; grant then stays on g, ignoring other requesters, until g's beat with last_pre_i=1 transfers.
REQ-021 A transferred beat with last=1 (from IDLE or LOCKED) SHALL return to IDLE and set ptr to g+1 modulo NUM_REQ in the same edge.
REQ-022 In IDLE the grant is combinational and is not committed until a transfer; a requester deasserting valid before transfer loses nothing and ptr does not move.
REQ-023 In LOCKED, valid_pre_i[g]=0 SHALL stall the output (no load) without releasing the lock.
REQ-024 Back-to-back packets: last beat of one requester and first beat of the next granted requester SHALL be accepted on consecutive cycles with no bubble.
REQ-025 No valid_pre_i asserted in IDLE: all ready_pre_o low, ptr unchanged, output drains normally.
REQ-026 src_post_o SHALL be registered alongside data_post_o and equal g of the captured beat.

Reset
REQ-027 rst_n low SHALL immediately force valid_post_o=0, last_post_o=0, data_post_o=0, src_post_o=0, ptr=0, state IDLE, ready_pre_o=0.
REQ-028 Reset asserted mid-packet SHALL discard the lock and any held beat; first grant after release follows ptr=0.

Structure
REQ-029 Shared package handshake_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_LOCKED) and the index-width function.
REQ-030 Round-robin priority select SHALL be a sub-module rr_pick (inputs: request vector, ptr; outputs: found, index); everything else stays in handshake_rr_arbiter.

Verification
REQ-031 Four single-beat requesters (last=1) always valid, ready_post_i=1 -> output src sequence 0,1,2,3,0,... one beat/cycle, data matches per-source counters.
REQ-032 Requester 2 sends 3-beat packet (0x10,0x11,0x12 last) while requester 0 stays valid -> 0x10..0x12 contiguous on output with src=2, then requester 3's/0's beat; ptr=3 after packet.
REQ-033 ready_post_i low for 5 cycles with valid_post_o=1 -> data_post_o/src_post_o unchanged, all ready_pre_o low, no beat lost or duplicated.
REQ-034 Locked requester 1 drops valid for 2 cycles mid-packet while requester 2 is valid -> no beat from requester 2 appears until requester 1's last beat.
REQ-035 rst_n pulsed low mid-packet -> outputs zero asynchronously; after release grant order restarts from index 0.
REQ-036 Random valid/ready stalls on all ports for 2000 cycles -> per-source data ordering intact, packets never interleaved, zero scoreboard errors.
